// File: rtl/shift_add_multiplier_if.sv
// Handshake/bus bundle for shift_add_multiplier.
//   start   : request pulse from the sequencer, sampled only while idle
//   a, b    : multiplicand / multiplier, captured on the accepting edge
//   sign_en : two's-complement operands (only with SHIFT_ADD_MULT_SIGNED_EN)
//   product : 2*WIDTH result register
//   busy    : high whenever the unit is not idle
//   done    : one-cycle completion pulse
// Handshake: the sequencer raises start while busy is low; the rising edge
// that sees start=1 in IDLE accepts a/b. busy stays high until the edge after
// done. product is valid in the done cycle and holds until the next done.
// start while busy is ignored (no queuing).
interface shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
  logic               sign_en;
`endif
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  modport master (output start, a, b, sign_en, input product, busy, done);
  modport slave  (input start, a, b, sign_en, output product, busy, done);
`else
  modport master (output start, a, b, input product, busy, done);
  modport slave  (input start, a, b, output product, busy, done);
`endif
endinterface

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-add sequential multiplier with early termination.
// Latency is bounded by the position of the highest set multiplier bit,
// so at most WIDTH cycles in RUN plus one DONE cycle.
// Optional macro: SHIFT_ADD_MULT_SIGNED_EN adds sign_en (sign-magnitude
// handling of two's-complement operands with a final negation).
// Ports:
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   bus       : shift_add_multiplier_if.slave (start/a/b/[sign_en]/product/busy/done)
//   state_dbg : current controller state (IDLE=0, RUN=1, DONE=2)
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  shift_add_multiplier_if.slave        bus,
  output logic [1:0]                   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mreg;
  logic [2*WIDTH-1:0] product_q;

  logic [2*WIDTH-1:0] sum;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   mreg_shift;
  logic               last;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // One RUN step: conditional add, then look at what remains of the multiplier.
  assign sum        = acc + (mreg[0] ? mcand : '0);
  assign mreg_shift = mreg >> 1;
  assign last       = (mreg_shift == '0);

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  logic neg;
  logic neg_load;

  // Magnitudes are unsigned WIDTH bits, so |-2^(WIDTH-1)| fits exactly.
  always_comb begin
    a_mag    = bus.a;
    b_mag    = bus.b;
    neg_load = 1'b0;
    if (bus.sign_en) begin
      if (bus.a[WIDTH-1]) a_mag = '0 - bus.a;
      if (bus.b[WIDTH-1]) b_mag = '0 - bus.b;
      neg_load = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end
  end

  assign result = neg ? ('0 - sum) : sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      neg <= neg_load;
    end
  end
`else
  assign a_mag  = bus.a;
  assign b_mag  = bus.b;
  assign result = sum;
`endif

  // Controller state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Controller next-state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand     <= '0;
      mreg      <= '0;
      acc       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= {{WIDTH{1'b0}}, a_mag};
            mreg  <= b_mag;
            acc   <= '0;
          end
        end
        RUN: begin
          acc   <= sum;
          mcand <= mcand << 1;
          mreg  <= mreg_shift;
          // product only moves on the RUN->DONE edge, so it holds through later runs.
          if (last) product_q <= result;
        end
        default: ;
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;
  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] prev_product;

  shift_add_multiplier_if #(.WIDTH(W)) bus ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operand values.
  function automatic logic [2*W-1:0] model_product(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                                   input logic s);
    int ia, ib, p;
    if (s) begin
      ia = int'($signed(ma));
      ib = int'($signed(mb));
    end else begin
      ia = int'(ma);
      ib = int'(mb);
    end
    p = ia * ib;
    return p[2*W-1:0];
  endfunction

  // Cycles spent in RUN: position of highest set bit of |b|, plus one (1 when zero).
  function automatic int model_k(input logic [W-1:0] mb, input logic s);
    int v, k;
    v = s ? int'($signed(mb)) : int'(mb);
    if (v < 0) v = -v;
    k = 1;
    for (int i = 0; i < 2 * W; i++) if ((v >> i) & 1) k = i + 1;
    return k;
  endfunction

  // Driver: called at a negedge; drives a request, follows it to the first IDLE cycle.
  // poke_run: pulse start with junk operands during RUN. poke_done: pulse start in DONE.
  task automatic do_mult(input logic [W-1:0] ta, input logic [W-1:0] tb_val, input logic s,
                         input logic poke_run, input logic poke_done);
    int n, k;
    logic [2*W-1:0] exp;
    exp = model_product(ta, tb_val, s);
    k   = model_k(tb_val, s);
    exp_q.push_back(exp);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_val;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    bus.sign_en = s;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n <= W + 2) begin
      check("busy_run", {31'd0, bus.busy}, 32'd1);
      check("product_hold", {16'd0, bus.product}, {16'd0, prev_product});
      if (poke_run && n == 2) begin
        bus.start = 1'b1;
        bus.a     = W'($urandom_range(0, 255));
        bus.b     = W'($urandom_range(0, 255));
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check("done_seen", {31'd0, bus.done}, 32'd1);
    check("done_cycle", n, k + 1);
    check("product", {16'd0, bus.product}, {16'd0, exp_q.pop_front()});
    check("busy_done", {31'd0, bus.busy}, 32'd1);
    prev_product = exp;
    if (poke_done) begin
      bus.start = 1'b1;
      bus.a     = 8'd9;
      bus.b     = 8'd9;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_done", {31'd0, bus.done}, 32'd0);
    check("idle_product", {16'd0, bus.product}, {16'd0, prev_product});
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    bus.sign_en = 1'b0;
`endif
    prev_product = '0;
    repeat (2) @(negedge clk);
    check("rst_product", {16'd0, bus.product}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_mult(8'd13, 8'd11, 1'b0, 1'b0, 1'b0);
    check("p_13x11", {16'd0, bus.product}, 32'd143);
    do_mult(8'd200, 8'd0, 1'b0, 1'b0, 1'b0);
    check("p_200x0", {16'd0, bus.product}, 32'd0);
    do_mult(8'd255, 8'd255, 1'b0, 1'b1, 1'b0);
    check("p_255x255", {16'd0, bus.product}, 32'd65025);

    // Reset in the middle of a run
    bus.start = 1'b1;
    bus.a     = 8'd7;
    bus.b     = 8'd128;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_done", {31'd0, bus.done}, 32'd0);
    check("mid_rst_product", {16'd0, bus.product}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    prev_product = '0;
    @(negedge clk);
    check("post_rst_done", {31'd0, bus.done}, 32'd0);
    do_mult(8'd3, 8'd4, 1'b0, 1'b0, 1'b0);
    check("p_3x4", {16'd0, bus.product}, 32'd12);

    // Back-to-back: start in DONE ignored, next IDLE cycle accepted
    do_mult(8'd5, 8'd6, 1'b0, 1'b0, 1'b1);
    check("p_5x6", {16'd0, bus.product}, 32'd30);
    do_mult(8'd9, 8'd9, 1'b0, 1'b0, 1'b0);
    check("p_9x9", {16'd0, bus.product}, 32'd81);

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    do_mult(8'hFD, 8'd5, 1'b1, 1'b0, 1'b0);
    check("p_m3x5", {16'd0, bus.product}, 32'h0000FFF1);
    do_mult(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
    check("p_m128xm128", {16'd0, bus.product}, 32'h00004000);
    for (int i = 0; i < 10; i++)
      do_mult(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
`endif

    // Randomized unsigned operations
    for (int i = 0; i < 20; i++)
      do_mult(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0,
              1'($urandom_range(0, 1)), 1'b0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
